// File: rtl/state_machine_1_pkg.sv
// state_machine_1_pkg: shared state encoding and default sizing for state_machine_1
package state_machine_1_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FINISH = 2'd2,
        ABORT  = 2'd3
    } state_t;
    localparam int DEF_COUNT_MAX = 100;
    localparam int DEF_CNT_W     = 7;
endpackage

// File: rtl/sm1_counter.sv
// sm1_counter: clearable enabled up-counter with terminal-count flag
//   clk, reset : clock, async active-high reset
//   clr, en    : synchronous clear (wins over en), count enable
//   tc         : high while count == COUNT_MAX
module sm1_counter
    import state_machine_1_pkg::*;
#(
    parameter int COUNT_MAX = DEF_COUNT_MAX,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    count <= '0;
        else if (clr) count <= '0;
        else if (en)  count <= count + 1'b1;
    end
    assign tc = count == CNT_W'(COUNT_MAX);
endmodule

// File: rtl/state_machine_1.sv
// state_machine_1: go-started fixed-length timed operation with kill abort and one-cycle done
//   clk, reset : clock, async active-high reset
//   go         : start request, honoured only in IDLE and only without kill
//   kill       : abort request, overrides counting and completion
//   done       : registered strobe, high for the single FINISH cycle
module state_machine_1
    import state_machine_1_pkg::*;
#(
    parameter int COUNT_MAX = DEF_COUNT_MAX,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic kill,
    output logic done
);
    state_t state, next;
    logic clr, en, tc, done_d;
    sm1_counter #(.COUNT_MAX(COUNT_MAX), .CNT_W(CNT_W)) u_cnt (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .tc(tc)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= next;
            done  <= done_d;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (go && !kill) ? ACTIVE : IDLE;
            ACTIVE:  next = kill ? ABORT : (tc ? FINISH : ACTIVE);
            FINISH:  next = IDLE;
            ABORT:   next = kill ? ABORT : IDLE;
            default: next = IDLE;
        endcase
    end
    // Counter only runs in ACTIVE; everywhere else it is held at zero so a new
    // run always starts from 0. done is registered from next so it is glitch-free.
    always_comb begin
        clr    = state != ACTIVE;
        en     = state == ACTIVE && !kill && !tc;
        done_d = next == FINISH;
    end
endmodule

// File: tb/tb_state_machine_1.sv
// tb_state_machine_1: randomized and directed check of state_machine_1 against a timing model
module tb_state_machine_1;
    logic clk = 1'b0;
    logic reset, go, kill;
    logic done_a, done_b;
    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    int cm[2] = '{100, 3};
    int ts[2];
    int fe[2];
    bit ab[2];

    state_machine_1 dut (
        .clk(clk), .reset(reset), .go(go), .kill(kill), .done(done_a)
    );
    state_machine_1 #(.COUNT_MAX(3), .CNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .go(go), .kill(kill), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            ts[i] = -1;
            fe[i] = -10;
            ab[i] = 1'b0;
        end
    endtask

    // A run started at edge s completes at edge s+cm+1 unless killed first;
    // after a kill, the first edge with kill low returns to idle.
    task automatic model_edge(input bit g, input bit k);
        for (int i = 0; i < 2; i++) begin
            if (ab[i]) begin
                if (!k) ab[i] = 1'b0;
            end else if (ts[i] >= 0) begin
                if (k) begin
                    ts[i] = -1;
                    ab[i] = 1'b1;
                end else if (n - ts[i] == cm[i] + 1) begin
                    ts[i] = -1;
                    fe[i] = n;
                end
            end else if (fe[i] != n - 1 && g && !k) begin
                ts[i] = n;
            end
        end
    endtask

    task automatic step(input bit g, input bit k);
        @(negedge clk);
        go = g;
        kill = k;
        @(posedge clk);
        n++;
        model_edge(g, k);
        #1;
        chk("done_cm100", done_a, fe[0] == n);
        chk("done_cm3", done_b, fe[1] == n);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0);
    endtask

    // Reset lands mid-cycle so its effect on done is seen before any clock edge.
    task automatic async_reset();
        #2;
        go = 1'b0;
        kill = 1'b0;
        reset = 1'b1;
        #1;
        model_clear();
        chk("reset_async_cm100", done_a, 1'b0);
        chk("reset_async_cm3", done_b, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held_cm100", done_a, 1'b0);
        chk("reset_held_cm3", done_b, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        go = 1'b0;
        kill = 1'b0;
        #12;
        chk("reset_init_cm100", done_a, 1'b0);
        chk("reset_init_cm3", done_b, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        // normal single-pulse run, then long quiet window
        step(1'b1, 1'b0);
        idle(220);
        // go together with kill in IDLE is blocked
        step(1'b1, 1'b1);
        idle(120);
        // kill mid-run for two cycles, then a fresh run
        step(1'b1, 1'b0);
        idle(25);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(110);
        // kill on the terminal-count edge
        step(1'b1, 1'b0);
        idle(100);
        step(1'b0, 1'b1);
        idle(110);
        // go pulsed mid-run is ignored
        step(1'b1, 1'b0);
        idle(40);
        step(1'b1, 1'b0);
        idle(110);
        // go held high restarts back-to-back
        for (int i = 0; i < 320; i++) step(1'b1, 1'b0);
        idle(110);
        // reset mid-ACTIVE, then no done without new go
        step(1'b1, 1'b0);
        idle(50);
        async_reset();
        idle(150);
        // reset while done is high
        step(1'b1, 1'b0);
        idle(101);
        async_reset();
        idle(10);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
